// File: rtl/panel_pkg.sv
// Shared definitions for front-panel display blocks: seven-segment patterns,
// the display radix and the per-radix digit width.
package panel_pkg;

    typedef enum logic {
        RADIX_OCT = 1'b0,
        RADIX_HEX = 1'b1
    } radix_e;

    // Active-low patterns, bit order g..a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int digit_width(input radix_e radix);
        case (radix)
            RADIX_HEX: return 4;
            RADIX_OCT: return 3;
            default:   return 3;
        endcase
    endfunction

endpackage

// File: rtl/panel_display_scan_seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern, with a
// blank request that turns every segment off.
module seg7_decode
    import panel_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Pattern lookup; blanking overrides the value
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_value)
                4'h0:    o_seg = SEG_0;
                4'h1:    o_seg = SEG_1;
                4'h2:    o_seg = SEG_2;
                4'h3:    o_seg = SEG_3;
                4'h4:    o_seg = SEG_4;
                4'h5:    o_seg = SEG_5;
                4'h6:    o_seg = SEG_6;
                4'h7:    o_seg = SEG_7;
                4'h8:    o_seg = SEG_8;
                4'h9:    o_seg = SEG_9;
                4'hA:    o_seg = SEG_A;
                4'hB:    o_seg = SEG_B;
                4'hC:    o_seg = SEG_C;
                4'hD:    o_seg = SEG_D;
                4'hE:    o_seg = SEG_E;
                4'hF:    o_seg = SEG_F;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/panel_display_scan.sv
// Multiplexed front-panel seven-segment scanner with channel stepping and
// anti-ghosting guard time. Leading-zero blanking under PANEL_ZERO_BLANK_EN.
module panel_display_scan
    import panel_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 12,
    parameter int NUM_CHAN   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CHAN*DATA_W-1:0]     chan_data,
    input  logic [NUM_DIGITS-1:0]          dots,
    input  logic                           radix_hex,
    input  logic                           next_chan,
    output logic [7:0]                     sevenseg,
    output logic [NUM_DIGITS-1:0]          sevenseg_an,
    output logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0] cur_chan
);

    localparam int CHAN_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int PAD_W   = (4 * NUM_DIGITS > DATA_W) ? 4 * NUM_DIGITS : DATA_W;
    localparam int OCT_W   = digit_width(RADIX_OCT);
    localparam int HEX_W   = digit_width(RADIX_HEX);

    logic [PRESC_W-1:0]    r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [CHAN_W-1:0]     r_chan;
    logic [DATA_W-1:0]     r_snap;
    logic [NUM_DIGITS-1:0] r_blank;
    logic                  r_prev;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_tick;
    logic                  w_frame;
    logic                  w_edge;
    logic                  w_guard;
    radix_e                w_radix;
    logic [DATA_W-1:0]     w_chan_val [NUM_CHAN];
    logic [PAD_W-1:0]      w_pad;
    logic [3:0]            w_oct [NUM_DIGITS];
    logic [3:0]            w_hex [NUM_DIGITS];
    logic [3:0]            w_digit;
    logic [NUM_DIGITS-1:0] w_new_blank;
    logic [6:0]            w_seg7;

    assign w_tick  = (r_presc == PRESC_W'(SCAN_DIV - 1));
    assign w_frame = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_edge  = next_chan & ~r_prev;
    assign w_guard = (r_presc < PRESC_W'(GUARD));
    assign w_radix = radix_e'(radix_hex);
    assign w_pad   = PAD_W'(r_snap);

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        assign w_chan_val[c] = chan_data[c*DATA_W +: DATA_W];
    end

    // Digits above DATA_W come from the zero padding of w_pad
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        assign w_oct[d] = {1'b0, w_pad[OCT_W*d +: OCT_W]};
        assign w_hex[d] = w_pad[HEX_W*d +: HEX_W];
    end

`ifdef PANEL_ZERO_BLANK_EN
    logic [PAD_W-1:0] w_new_pad;
    assign w_new_pad = PAD_W'(w_chan_val[r_chan]);

    // A digit blanks when it and every more-significant bit are zero
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_blank
        if (d == 0) begin : g_lsd
            assign w_new_blank[d] = 1'b0;
        end else begin : g_upper
            assign w_new_blank[d] = (w_radix == RADIX_HEX) ? ~|w_new_pad[PAD_W-1:HEX_W*d]
                                                           : ~|w_new_pad[PAD_W-1:OCT_W*d];
        end
    end
`else
    assign w_new_blank = '0;
`endif

    // Current slot's digit value in the selected radix
    always_comb begin
        w_digit = 4'd0;
        if (w_radix == RADIX_HEX) begin
            w_digit = w_hex[r_idx];
        end else begin
            w_digit = w_oct[r_idx];
        end
    end

    seg7_decode u_seg7_decode (
        .i_value (w_digit),
        .i_blank (r_blank[r_idx]),
        .o_seg   (w_seg7)
    );

    // Scan timing, channel stepping, frame snapshot and registered drive
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_chan  <= '0;
            r_snap  <= '0;
            r_blank <= '0;
            r_prev  <= 1'b0;
            r_seg   <= 8'hFF;
            r_an    <= '1;
        end else begin
            r_prev <= next_chan;
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
            // Snapshot uses the channel before any coincident step
            if (w_frame) begin
                r_snap  <= w_chan_val[r_chan];
                r_blank <= w_new_blank;
            end
            if (w_edge) begin
                r_chan <= (r_chan == CHAN_W'(NUM_CHAN - 1)) ? '0 : r_chan + CHAN_W'(1);
            end
            if (w_guard) begin
                r_seg <= 8'hFF;
                r_an  <= '1;
            end else begin
                r_seg <= {~dots[r_idx], w_seg7};
                r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            end
        end
    end

    assign sevenseg    = r_seg;
    assign sevenseg_an = r_an;
    assign cur_chan    = r_chan;

endmodule
